// File: rtl/cache_pkg.sv
// Shared definitions for the cache/memory arbitration slice.
//   state_e    : arbiter FSM states (IDLE, ISSUE, WAIT, DONE), 2 bits
//   PORT_I/D   : requester indices (instruction cache = 0, data cache = 1)
//   MRW_READ/
//   MRW_WRITE  : encoding of the MRW request bit
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic PORT_I    = 1'b0;
  localparam logic PORT_D    = 1'b1;

  localparam logic MRW_READ  = 1'b1;
  localparam logic MRW_WRITE = 1'b0;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times out the fixed memory latency.
//   clk    : clock, posedge
//   reset  : synchronous active-low reset (count -> 0)
//   LdCtr  : load LdVal this cycle (takes priority over counting)
//   LdVal  : load value
//   CtrSig : high while the count equals 1 (last wait cycle)
// The count decrements every cycle it is non-zero and holds at 0, so it never wraps.
module mem_lat_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          LdCtr,
  input  logic [CW-1:0] LdVal,
  output logic          CtrSig
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (LdCtr) begin
      cnt_d = LdVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CtrSig = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a fixed-latency main memory.
// Port 0 is the instruction-cache controller, port 1 the data-cache controller.
// Ports:
//   clk, reset            : clock (posedge) and synchronous active-low reset
//   MStrobe0/1            : request, held until the port's Rdy
//   MRW0/1                : 1 = read, 0 = write
//   MAddr0/1, MWData0/1   : request address / write data
//   Rdy0/1                : one-cycle completion pulse to the granted port
//   RData                 : read data, valid while Rdy0 or Rdy1 is high
//   MemStrobe             : one-cycle memory start pulse
//   MemRW/MemAddr/MemWData: latched request of the winner
//   MemRData              : memory read data, valid in the last WAIT cycle
//   Busy                  : high whenever the FSM is not IDLE
//   Gnt                   : current or last granted port
// Build option: define ARB_FIXED_PRIO_EN to make port 1 win every tie
// (otherwise ties are resolved round-robin).
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MStrobe0,
  input  logic          MStrobe1,
  input  logic          MRW0,
  input  logic          MRW1,
  input  logic [AW-1:0] MAddr0,
  input  logic [AW-1:0] MAddr1,
  input  logic [DW-1:0] MWData0,
  input  logic [DW-1:0] MWData1,
  output logic          Rdy0,
  output logic          Rdy1,
  output logic [DW-1:0] RData,
  output logic          MemStrobe,
  output logic          MemRW,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          Busy,
  output logic          Gnt
);

  localparam int unsigned CtrW = $clog2(LATENCY + 1);
  localparam logic [CtrW-1:0] LatVal = CtrW'(LATENCY);

  state_e        state_q, state_d;
  logic          gnt_q;
  logic          mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;

  logic          req_any;
  logic          winner;
  logic          grant;
  logic          ld_ctr;
  logic          ctr_sig;

  assign req_any = MStrobe0 | MStrobe1;
  // Grant is taken on the edge leaving IDLE.
  assign grant   = (state_q == IDLE) && req_any;

`ifdef ARB_FIXED_PRIO_EN
  // Data cache wins every tie; no history is kept.
  always_comb begin
    winner = PORT_I;
    if (MStrobe1) begin
      winner = PORT_D;
    end
  end
`else
  logic last_gnt_q;

  // Round-robin: on a tie the port that did not win last time is served.
  always_comb begin
    winner = PORT_I;
    if (MStrobe0 && MStrobe1) begin
      winner = ~last_gnt_q;
    end else if (MStrobe1) begin
      winner = PORT_D;
    end
  end

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_gnt_q <= PORT_D;
    end else if (grant) begin
      last_gnt_q <= winner;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ld_ctr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ld_ctr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (ctr_sig) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch: the winner's request governs the whole transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q       <= PORT_I;
      mem_rw_q    <= MRW_WRITE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant) begin
      gnt_q       <= winner;
      mem_rw_q    <= (winner == PORT_D) ? MRW1    : MRW0;
      mem_addr_q  <= (winner == PORT_D) ? MAddr1  : MAddr0;
      mem_wdata_q <= (winner == PORT_D) ? MWData1 : MWData0;
    end
  end

  // Read data is captured in the last WAIT cycle; writes leave it untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if ((state_q == WAIT) && ctr_sig && (mem_rw_q == MRW_READ)) begin
      rdata_q <= MemRData;
    end
  end

  mem_lat_counter #(
    .CW (CtrW)
  ) u_mem_lat_counter (
    .clk    (clk),
    .reset  (reset),
    .LdCtr  (ld_ctr),
    .LdVal  (LatVal),
    .CtrSig (ctr_sig)
  );

  // Outputs decoded from registered state, so all are 0 out of reset.
  always_comb begin
    MemStrobe = (state_q == ISSUE);
    Busy      = (state_q != IDLE);
    Rdy0      = (state_q == DONE) && (gnt_q == PORT_I);
    Rdy1      = (state_q == DONE) && (gnt_q == PORT_D);
  end

  assign Gnt      = gnt_q;
  assign MemRW    = mem_rw_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign RData    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (AW=16, DW=32, LATENCY=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LATENCY = 4;

  logic          clk;
  logic          reset;
  logic          MStrobe0, MStrobe1;
  logic          MRW0, MRW1;
  logic [AW-1:0] MAddr0, MAddr1;
  logic [DW-1:0] MWData0, MWData1;
  logic          Rdy0, Rdy1;
  logic [DW-1:0] RData;
  logic          MemStrobe;
  logic          MemRW;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;
  logic          Busy;
  logic          Gnt;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MStrobe0  (MStrobe0),
    .MStrobe1  (MStrobe1),
    .MRW0      (MRW0),
    .MRW1      (MRW1),
    .MAddr0    (MAddr0),
    .MAddr1    (MAddr1),
    .MWData0   (MWData0),
    .MWData1   (MWData1),
    .Rdy0      (Rdy0),
    .Rdy1      (Rdy1),
    .RData     (RData),
    .MemStrobe (MemStrobe),
    .MemRW     (MemRW),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .Busy      (Busy),
    .Gnt       (Gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic first_w, second_w;
  logic exp_g [3];

  initial begin
    reset    = 1'b0;
    MStrobe0 = 1'b0; MStrobe1 = 1'b0;
    MRW0     = 1'b0; MRW1     = 1'b0;
    MAddr0   = '0;   MAddr1   = '0;
    MWData0  = '0;   MWData1  = '0;
    MemRData = '0;

`ifdef ARB_FIXED_PRIO_EN
    first_w = 1'b1; second_w = 1'b0;
    exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1;
`else
    first_w = 1'b0; second_w = 1'b1;
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
`endif

    // Reset values.
    tick();
    tick();
    check("rst_gnt", Gnt, 0);
    check("rst_memstrobe", MemStrobe, 0);
    check("rst_memrw", MemRW, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_memwdata", MemWData, 0);
    check("rst_rdata", RData, 0);
    check("rst_rdy0", Rdy0, 0);
    check("rst_rdy1", Rdy1, 0);
    check("rst_busy", Busy, 0);
    reset = 1'b1;

    // Port 0 read of 0x0010; cycle 0 is this IDLE cycle.
    MStrobe0 = 1'b1; MRW0 = 1'b1; MAddr0 = 16'h0010; MemRData = 32'hDEADBEEF;
    tick(); // cycle 1
    check("rd_strobe_c1", MemStrobe, 1);
    check("rd_gnt_c1", Gnt, 0);
    check("rd_addr_c1", MemAddr, 16'h0010);
    check("rd_rw_c1", MemRW, 1);
    tick(); // cycle 2
    check("rd_strobe_c2", MemStrobe, 0);
    MAddr0 = 16'h0099;  // ignored outside IDLE
    tick(); tick(); // cycle 4
    check("rd_addr_hold", MemAddr, 16'h0010);
    check("rd_rdy0_c4", Rdy0, 0);
    tick(); // cycle 5
    check("rd_rdy0_c5", Rdy0, 0);
    check("rd_busy_c5", Busy, 1);
    tick(); // cycle 6
    check("rd_rdy0_c6", Rdy0, 1);
    check("rd_rdy1_c6", Rdy1, 0);
    check("rd_rdata_c6", RData, 32'hDEADBEEF);
    MStrobe0 = 1'b0;
    tick(); // cycle 7, IDLE
    check("rd_rdy0_c7", Rdy0, 0);
    check("rd_busy_c7", Busy, 0);

    // Port 1 write of 0x0020; RData must keep 0xDEADBEEF.
    MStrobe1 = 1'b1; MRW1 = 1'b0; MAddr1 = 16'h0020; MWData1 = 32'h12345678;
    MemRData = 32'hCAFEF00D;
    tick(); // cycle 1
    check("wr_strobe_c1", MemStrobe, 1);
    check("wr_gnt_c1", Gnt, 1);
    check("wr_rw_c1", MemRW, 0);
    check("wr_addr_c1", MemAddr, 16'h0020);
    check("wr_wdata_c1", MemWData, 32'h12345678);
    tick(); tick(); tick(); tick(); // cycle 5
    check("wr_rdy1_c5", Rdy1, 0);
    tick(); // cycle 6
    check("wr_rdy1_c6", Rdy1, 1);
    check("wr_rdy0_c6", Rdy0, 0);
    check("wr_rdata_kept", RData, 32'hDEADBEEF);
    MStrobe1 = 1'b0;
    tick();
    check("wr_busy_c7", Busy, 0);

    // Reset in cycle 3 of a read drops the transaction.
    MStrobe0 = 1'b1; MRW0 = 1'b1; MAddr0 = 16'h0030; MemRData = 32'h55AA55AA;
    tick(); tick(); tick(); // cycle 3
    check("mr_busy_c3", Busy, 1);
    reset = 1'b0;
    tick(); // cycle 4
    check("mr_busy", Busy, 0);
    check("mr_memaddr", MemAddr, 0);
    check("mr_memrw", MemRW, 0);
    check("mr_rdata", RData, 0);
    check("mr_gnt", Gnt, 0);
    check("mr_rdy0", Rdy0, 0);
    MStrobe0 = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mr_no_rdy0", Rdy0, 0);
      check("mr_idle_busy", Busy, 0);
    end

    // Tie after reset; each requester drops its strobe after its Rdy.
    do_reset();
    MStrobe0 = 1'b1; MStrobe1 = 1'b1; MRW0 = 1'b1; MRW1 = 1'b1;
    MAddr0 = 16'h0040; MAddr1 = 16'h0050; MemRData = 32'h01020304;
    tick(); // cycle 1
    check("tie_gnt_first", Gnt, first_w);
    check("tie_addr_first", MemAddr, first_w ? 16'h0050 : 16'h0040);
    tick(); tick(); tick(); tick(); tick(); // cycle 6
    check("tie_rdy0_first", Rdy0, !first_w);
    check("tie_rdy1_first", Rdy1, first_w);
    if (first_w) MStrobe1 = 1'b0; else MStrobe0 = 1'b0;
    tick(); // cycle 7, IDLE
    check("tie_busy_gap", Busy, 0);
    tick(); // cycle 8
    check("tie_gnt_second", Gnt, second_w);
    check("tie_addr_second", MemAddr, second_w ? 16'h0050 : 16'h0040);
    tick(); tick(); tick(); tick(); tick(); // cycle 13
    check("tie_rdy0_second", Rdy0, !second_w);
    check("tie_rdy1_second", Rdy1, second_w);
    MStrobe0 = 1'b0; MStrobe1 = 1'b0;
    tick();

    // Back-to-back with both strobes held high: 7 cycles per transaction.
    do_reset();
    MStrobe0 = 1'b1; MStrobe1 = 1'b1; MRW0 = 1'b1; MRW1 = 1'b1;
    MAddr0 = 16'h0100; MAddr1 = 16'h0200;
    for (int t = 0; t < 3; t++) begin
      MemRData = 32'hA0000000 | 32'(t);
      check("b2b_idle_busy", Busy, 0);
      tick(); // cycle 1
      check("b2b_gnt", Gnt, exp_g[t]);
      check("b2b_strobe", MemStrobe, 1);
      check("b2b_addr", MemAddr, exp_g[t] ? 16'h0200 : 16'h0100);
      for (int k = 2; k <= 5; k++) begin
        tick();
        check("b2b_busy_wait", Busy, 1);
      end
      tick(); // cycle 6
      check("b2b_rdy0", Rdy0, !exp_g[t]);
      check("b2b_rdy1", Rdy1, exp_g[t]);
      check("b2b_rdata", RData, 32'hA0000000 | 32'(t));
      tick(); // cycle 7, IDLE of next transaction
    end
    MStrobe0 = 1'b0; MStrobe1 = 1'b0;
    tick();
    tick();
    check("end_busy", Busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
